sdram_traffic_checker: RTL and testbench

//  Self-checking traffic generator for the FIFO-fronted SDRAM controller on the 50 MHz user side.

---
 rtl/sdram_tg_pkg.sv | 31 +++
 rtl/sdram_pattern_gen.sv | 34 +++
 rtl/sdram_traffic_checker.sv | 239 +++++++++++++++++++++++
 tb/tb_sdram_traffic_checker.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_tg_pkg.sv
// Shared constants for the SDRAM traffic checker: FSM encoding, pattern codes, LFSR taps.
package sdram_tg_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] ST_WAIT_INIT = 3'd1;
  localparam logic [STATE_W-1:0] ST_WRITE     = 3'd2;
  localparam logic [STATE_W-1:0] ST_FLUSH     = 3'd3;
  localparam logic [STATE_W-1:0] ST_FILL      = 3'd4;
  localparam logic [STATE_W-1:0] ST_DRAIN     = 3'd5;
  localparam logic [STATE_W-1:0] ST_NEXT      = 3'd6;

  localparam int unsigned PATTERN_INC  = 0;
  localparam int unsigned PATTERN_LFSR = 1;

  localparam int unsigned SEED_W = 16;
  localparam int unsigned LFSR_W = 16;

  // x^16 + x^14 + x^13 + x^11 + 1, taps on bits 15, 13, 12, 10
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  // Cycles to wait in FLUSH before trusting wr_fifo_num, so the final push is visible in the level
  localparam int unsigned FLUSH_SETTLE = 2;

  // One Fibonacci step: shift left, feed back XOR of the tapped bits
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/sdram_pattern_gen.sv
// Seedable pattern source: incrementing counter or 16-bit LFSR, advanced one word per strobe.
module sdram_pattern_gen
  import sdram_tg_pkg::*;
#(
  parameter int unsigned DW      = 16,
  parameter int unsigned PATTERN = PATTERN_INC
) (
  input  logic              clk_50m,
  input  logic              rst_n,
  input  logic              load,
  input  logic [SEED_W-1:0] seed,
  input  logic              advance,
  output logic [DW-1:0]     value
);

  // LFSR mode is defined only for a 16-bit datapath
  if (PATTERN == PATTERN_LFSR && DW != LFSR_W) begin : g_bad_dw
    $error("sdram_pattern_gen: PATTERN=1 requires DW=16");
  end

  // Load seeds the sequence (LFSR forced odd so it can never lock at zero); advance steps it
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      if (PATTERN == PATTERN_LFSR) value <= DW'({seed[SEED_W-2:0], 1'b1});
      else                         value <= DW'(seed);
    end else if (advance) begin
      if (PATTERN == PATTERN_LFSR) value <= DW'(lfsr_next(LFSR_W'(value)));
      else                         value <= value + DW'(1);
    end
  end

endmodule

// File: rtl/sdram_traffic_checker.sv
// Write/read-back BIST for the FIFO-fronted SDRAM controller: pushes a pattern, reads it back, counts mismatches.
module sdram_traffic_checker
  import sdram_tg_pkg::*;
#(
  parameter int unsigned DW        = 16,
  parameter int unsigned FNUM_W    = 10,
  parameter int unsigned NUM_WORDS = 30,
  parameter int unsigned WR_GAP    = 7,
  parameter int unsigned PATTERN   = PATTERN_INC,
  parameter int unsigned PASSES    = 1,
  parameter int unsigned TIMEOUT   = 65535
) (
  input  logic              clk_50m,
  input  logic              rst_n,
  input  logic              start,
  input  logic              init_end,
  output logic              wr_fifo_wr_req,
  output logic [DW-1:0]     wr_fifo_wr_data,
  input  logic [FNUM_W-1:0] wr_fifo_num,
  output logic              read_valid,
  output logic              rd_fifo_rd_req,
  input  logic [DW-1:0]     rd_fifo_rd_data,
  input  logic [FNUM_W-1:0] rd_fifo_num,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_cnt,
  output logic              timeout
);

  localparam int unsigned WCNT_W = $clog2(NUM_WORDS + 1);
  localparam int unsigned GAP_W  = (WR_GAP > 0) ? $clog2(WR_GAP + 1) : 1;
  localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned PIDX_W = $clog2(PASSES + 1);

  if (NUM_WORDS < 1 || NUM_WORDS >= (1 << FNUM_W)) begin : g_bad_nw
    $error("sdram_traffic_checker: NUM_WORDS out of range for FNUM_W");
  end
  if (PASSES < 1 || TIMEOUT < 1) begin : g_bad_cfg
    $error("sdram_traffic_checker: PASSES and TIMEOUT must be at least 1");
  end

  logic [STATE_W-1:0] state, state_nxt;
  logic [GAP_W-1:0]   gap_cnt, gap_nxt;
  logic [WCNT_W-1:0]  word_cnt, word_nxt;
  logic [WCNT_W-1:0]  cmp_cnt, cmp_nxt;
  logic [TMO_W-1:0]   tmo_cnt, tmo_nxt;
  logic [PIDX_W-1:0]  pass_idx, pass_idx_nxt;
  logic [15:0]        err_nxt;
  logic               timeout_nxt, pass_nxt, done_nxt, busy_nxt;
  logic               wr_req_nxt, read_valid_nxt, rd_req_nxt;
  logic [DW-1:0]      wr_data_nxt;
  logic               cmp_vld;
  logic               gen_load, push, abort, tmo_hit, mismatch;
  logic [DW-1:0]      wr_value, chk_value;
  logic [SEED_W-1:0]  seed;

  assign seed = SEED_W'(pass_idx_nxt);

  sdram_pattern_gen #(.DW(DW), .PATTERN(PATTERN)) u_writer (
    .clk_50m (clk_50m),
    .rst_n   (rst_n),
    .load    (gen_load),
    .seed    (seed),
    .advance (push),
    .value   (wr_value)
  );

  sdram_pattern_gen #(.DW(DW), .PATTERN(PATTERN)) u_checker (
    .clk_50m (clk_50m),
    .rst_n   (rst_n),
    .load    (gen_load),
    .seed    (seed),
    .advance (cmp_vld),
    .value   (chk_value)
  );

  // Next-state and next-output decode for the whole run sequence
  always_comb begin
    state_nxt      = state;
    gap_nxt        = gap_cnt;
    word_nxt       = word_cnt;
    cmp_nxt        = cmp_cnt;
    pass_idx_nxt   = pass_idx;
    err_nxt        = err_cnt;
    timeout_nxt    = timeout;
    pass_nxt       = pass;
    done_nxt       = 1'b0;
    busy_nxt       = busy;
    wr_req_nxt     = 1'b0;
    wr_data_nxt    = wr_fifo_wr_data;
    read_valid_nxt = 1'b0;
    rd_req_nxt     = 1'b0;
    gen_load       = 1'b0;
    push           = 1'b0;
    abort          = 1'b0;
    tmo_hit        = (tmo_cnt == TMO_W'(TIMEOUT - 1));
    mismatch       = cmp_vld && (rd_fifo_rd_data != chk_value);
    tmo_nxt        = tmo_cnt;

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt    = ST_WAIT_INIT;
          busy_nxt     = 1'b1;
          err_nxt      = '0;
          timeout_nxt  = 1'b0;
          pass_nxt     = 1'b0;
          pass_idx_nxt = '0;
        end
      end
      ST_WAIT_INIT: begin
        if (init_end) begin
          state_nxt = ST_WRITE;
          gen_load  = 1'b1;
          gap_nxt   = '0;
          word_nxt  = '0;
        end else if (tmo_hit) begin
          abort = 1'b1;
        end
      end
      ST_WRITE: begin
        if (gap_cnt == GAP_W'(WR_GAP)) begin
          push        = 1'b1;
          wr_req_nxt  = 1'b1;
          wr_data_nxt = wr_value;
          gap_nxt     = '0;
          word_nxt    = word_cnt + WCNT_W'(1);
          if (word_cnt == WCNT_W'(NUM_WORDS - 1)) state_nxt = ST_FLUSH;
        end else begin
          gap_nxt = gap_cnt + GAP_W'(1);
        end
      end
      ST_FLUSH: begin
        if (tmo_cnt >= TMO_W'(FLUSH_SETTLE) && wr_fifo_num == '0) begin
          state_nxt      = ST_FILL;
          read_valid_nxt = 1'b1;
        end else if (tmo_hit) begin
          abort = 1'b1;
        end
      end
      ST_FILL: begin
        if (rd_fifo_num >= FNUM_W'(NUM_WORDS)) begin
          state_nxt  = ST_DRAIN;
          rd_req_nxt = 1'b1;
          word_nxt   = WCNT_W'(1);
          cmp_nxt    = '0;
        end else if (tmo_hit) begin
          abort = 1'b1;
        end else begin
          read_valid_nxt = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (word_cnt != WCNT_W'(NUM_WORDS)) begin
          rd_req_nxt = 1'b1;
          word_nxt   = word_cnt + WCNT_W'(1);
        end
        if (cmp_vld) begin
          if (mismatch && err_cnt != 16'hFFFF) err_nxt = err_cnt + 16'd1;
          cmp_nxt = cmp_cnt + WCNT_W'(1);
          if (cmp_cnt == WCNT_W'(NUM_WORDS - 1)) state_nxt = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (pass_idx == PIDX_W'(PASSES - 1)) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          pass_nxt  = (err_cnt == 16'd0) && !timeout;
        end else begin
          state_nxt    = ST_WRITE;
          pass_idx_nxt = pass_idx + PIDX_W'(1);
          gen_load     = 1'b1;
          gap_nxt      = '0;
          word_nxt     = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    if (abort) begin
      state_nxt      = ST_IDLE;
      timeout_nxt    = 1'b1;
      done_nxt       = 1'b1;
      pass_nxt       = 1'b0;
      busy_nxt       = 1'b0;
      wr_req_nxt     = 1'b0;
      read_valid_nxt = 1'b0;
      rd_req_nxt     = 1'b0;
    end

    // Per-state wait counter: restarts on any state change, saturates at the abort threshold
    if (state_nxt != state) tmo_nxt = '0;
    else if (!tmo_hit)      tmo_nxt = tmo_cnt + TMO_W'(1);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      gap_cnt         <= '0;
      word_cnt        <= '0;
      cmp_cnt         <= '0;
      tmo_cnt         <= '0;
      pass_idx        <= '0;
      err_cnt         <= '0;
      timeout         <= 1'b0;
      pass            <= 1'b0;
      done            <= 1'b0;
      busy            <= 1'b0;
      wr_fifo_wr_req  <= 1'b0;
      wr_fifo_wr_data <= '0;
      read_valid      <= 1'b0;
      rd_fifo_rd_req  <= 1'b0;
      cmp_vld         <= 1'b0;
    end else begin
      state           <= state_nxt;
      gap_cnt         <= gap_nxt;
      word_cnt        <= word_nxt;
      cmp_cnt         <= cmp_nxt;
      tmo_cnt         <= tmo_nxt;
      pass_idx        <= pass_idx_nxt;
      err_cnt         <= err_nxt;
      timeout         <= timeout_nxt;
      pass            <= pass_nxt;
      done            <= done_nxt;
      busy            <= busy_nxt;
      wr_fifo_wr_req  <= wr_req_nxt;
      wr_fifo_wr_data <= wr_data_nxt;
      read_valid      <= read_valid_nxt;
      rd_fifo_rd_req  <= rd_req_nxt;
      cmp_vld         <= rd_fifo_rd_req;
    end
  end

endmodule

// File: tb/tb_sdram_traffic_checker.sv
// Bench: two checkers (incrementing/gapped and LFSR/single-word) against a queue-based FIFO + SDRAM model.
module tb_sdram_traffic_checker;

  localparam int unsigned DW     = 16;
  localparam int unsigned FNUM_W = 10;
  localparam int unsigned NW0    = 30;
  localparam int unsigned GAP0   = 7;
  localparam int unsigned PS0    = 1;
  localparam int unsigned TMO0   = 100;
  localparam int unsigned NW1    = 1;
  localparam int unsigned PS1    = 3;

  logic clk_50m = 1'b0;
  always #10 clk_50m = ~clk_50m;

  logic              rst_n;
  logic              init_end;
  logic              start      [2];
  logic              wr_req     [2];
  logic              read_valid [2];
  logic              rd_req     [2];
  logic              busy       [2];
  logic              done       [2];
  logic              pass       [2];
  logic              timeout    [2];
  logic [15:0]       err_cnt    [2];
  logic [DW-1:0]     wr_data    [2];
  logic [DW-1:0]     rd_data    [2];
  logic [FNUM_W-1:0] wr_num     [2];
  logic [FNUM_W-1:0] rd_num     [2];

  sdram_traffic_checker #(
    .DW(DW), .FNUM_W(FNUM_W), .NUM_WORDS(NW0), .WR_GAP(GAP0),
    .PATTERN(0), .PASSES(PS0), .TIMEOUT(TMO0)
  ) u_dut0 (
    .clk_50m(clk_50m), .rst_n(rst_n), .start(start[0]), .init_end(init_end),
    .wr_fifo_wr_req(wr_req[0]), .wr_fifo_wr_data(wr_data[0]), .wr_fifo_num(wr_num[0]),
    .read_valid(read_valid[0]), .rd_fifo_rd_req(rd_req[0]), .rd_fifo_rd_data(rd_data[0]),
    .rd_fifo_num(rd_num[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .err_cnt(err_cnt[0]), .timeout(timeout[0])
  );

  sdram_traffic_checker #(
    .DW(DW), .FNUM_W(FNUM_W), .NUM_WORDS(NW1), .WR_GAP(0),
    .PATTERN(1), .PASSES(PS1), .TIMEOUT(65535)
  ) u_dut1 (
    .clk_50m(clk_50m), .rst_n(rst_n), .start(start[1]), .init_end(init_end),
    .wr_fifo_wr_req(wr_req[1]), .wr_fifo_wr_data(wr_data[1]), .wr_fifo_num(wr_num[1]),
    .read_valid(read_valid[1]), .rd_fifo_rd_req(rd_req[1]), .rd_fifo_rd_data(rd_data[1]),
    .rd_fifo_num(rd_num[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_cnt(err_cnt[1]), .timeout(timeout[1])
  );

  // ---------------- FIFO + controller + SDRAM model ----------------
  logic [DW-1:0] wq  [2][$];
  logic [DW-1:0] mem [2][$];
  logic [DW-1:0] rq  [2][$];
  int            ctl_div [2];
  int            pop_idx [2];
  int            cyc;
  logic          inject;

  // Write FIFO drains to SDRAM every 3rd cycle; read FIFO refills every other cycle while read_valid
  always @(posedge clk_50m) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        wq[k].delete();
        mem[k].delete();
        rq[k].delete();
        ctl_div[k] <= 0;
        pop_idx[k] <= 0;
        rd_data[k] <= '0;
      end else begin
        if (start[k] && !busy[k]) pop_idx[k] <= 0;
        if (wr_req[k]) wq[k].push_back(wr_data[k]);
        if (ctl_div[k] == 2 && wq[k].size() > 0) mem[k].push_back(wq[k].pop_front());
        ctl_div[k] <= (ctl_div[k] == 2) ? 0 : ctl_div[k] + 1;
        if (read_valid[k] && cyc[0] && mem[k].size() > 0) rq[k].push_back(mem[k].pop_front());
        if (rd_req[k]) begin
          rd_data[k] <= ((rq[k].size() > 0) ? rq[k].pop_front() : 16'hDEAD) |
                        ((inject && k == 0 && pop_idx[0] == 5) ? 16'h0008 : 16'h0000);
          pop_idx[k] <= pop_idx[k] + 1;
        end
      end
      wr_num[k] <= FNUM_W'(wq[k].size());
      rd_num[k] <= FNUM_W'(rq[k].size());
    end
  end

  // ---------------- scoreboard ----------------
  int            n_checks;
  int            n_errors;
  int            exp_err_set;
  bit            exp_tmo_set;
  logic [DW-1:0] exp_wr [2][$];
  int            done_cnt [2];
  int            done_cyc [2];
  int            pushes_run [2];
  int            pops_run [2];
  int            viol [2];
  int            last_push [2];
  int            push_in_pass [2];
  int            run_exp_err [2];
  bit            run_exp_tmo [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Queue every word the writer must push for a whole run
  task automatic load_expectations(input int k);
    int np = (k == 0) ? PS0 : PS1;
    int nw = (k == 0) ? NW0 : NW1;
    for (int p = 0; p < np; p++) begin
      logic [15:0] s = {15'(p), 1'b1};
      for (int i = 0; i < nw; i++) begin
        if (k == 0) exp_wr[k].push_back(16'(p + i));
        else        exp_wr[k].push_back(s);
        s = lfsr_step(s);
      end
    end
  endtask

  task automatic monitor_step();
    for (int k = 0; k < 2; k++) begin
      int nw = (k == 0) ? NW0 : NW1;
      int np = (k == 0) ? PS0 : PS1;
      logic [31:0] exp;
      if (!rst_n) begin
        exp_wr[k].delete();
        pushes_run[k] = 0; pops_run[k] = 0; viol[k] = 0; push_in_pass[k] = 0;
        continue;
      end
      if (start[k] && !busy[k]) begin
        exp_wr[k].delete();
        pushes_run[k] = 0; pops_run[k] = 0; viol[k] = 0; push_in_pass[k] = 0;
        run_exp_err[k] = exp_err_set;
        run_exp_tmo[k] = exp_tmo_set;
        if (!exp_tmo_set) load_expectations(k);
      end
      if ((wr_req[k] && rd_req[k]) || (read_valid[k] && (wr_req[k] || rd_req[k]))) viol[k]++;
      if (wr_req[k]) begin
        exp = (exp_wr[k].size() > 0) ? 32'(exp_wr[k].pop_front()) : 32'hFFFF_FFFF;
        check_eq($sformatf("u%0d_wr_data[%0d]", k, pushes_run[k]), 32'(wr_data[k]), exp);
        if (k == 0 && push_in_pass[0] != 0) check_eq("u0_wr_gap", 32'(cyc - last_push[0]), GAP0 + 1);
        last_push[k] = cyc;
        push_in_pass[k] = (push_in_pass[k] + 1 == nw) ? 0 : push_in_pass[k] + 1;
        pushes_run[k]++;
      end
      if (rd_req[k]) pops_run[k]++;
      if (done[k]) begin
        done_cnt[k]++;
        done_cyc[k] = cyc;
        check_eq($sformatf("u%0d_err_cnt", k), 32'(err_cnt[k]), 32'(run_exp_err[k]));
        check_eq($sformatf("u%0d_pass", k), 32'(pass[k]), 32'(!run_exp_tmo[k] && run_exp_err[k] == 0));
        check_eq($sformatf("u%0d_timeout", k), 32'(timeout[k]), 32'(run_exp_tmo[k]));
        check_eq($sformatf("u%0d_pushes", k), 32'(pushes_run[k]), run_exp_tmo[k] ? 0 : 32'(nw * np));
        check_eq($sformatf("u%0d_pops", k), 32'(pops_run[k]), run_exp_tmo[k] ? 0 : 32'(nw * np));
        check_eq($sformatf("u%0d_wr_left", k), 32'(exp_wr[k].size()), 0);
        check_eq($sformatf("u%0d_strobe_excl", k), 32'(viol[k]), 0);
        check_eq($sformatf("u%0d_busy_at_done", k), 32'(busy[k]), 0);
      end
    end
  endtask

  task automatic pulse_start(input int k);
    @(posedge clk_50m); #1;
    start[k] = 1'b1;
    @(posedge clk_50m); #1;
    start[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int budget);
    int n0 = done_cnt[k];
    int c  = 0;
    while (done_cnt[k] == n0 && c < budget) begin
      @(posedge clk_50m);
      c++;
    end
    check_eq($sformatf("u%0d_done_seen", k), 32'(done_cnt[k] != n0), 1);
  endtask

  task automatic check_all_zero(input string tag, input int k);
    check_eq({tag, "_busy"}, 32'(busy[k]), 0);
    check_eq({tag, "_done"}, 32'(done[k]), 0);
    check_eq({tag, "_pass"}, 32'(pass[k]), 0);
    check_eq({tag, "_timeout"}, 32'(timeout[k]), 0);
    check_eq({tag, "_err_cnt"}, 32'(err_cnt[k]), 0);
    check_eq({tag, "_wr_req"}, 32'(wr_req[k]), 0);
    check_eq({tag, "_wr_data"}, 32'(wr_data[k]), 0);
    check_eq({tag, "_read_valid"}, 32'(read_valid[k]), 0);
    check_eq({tag, "_rd_req"}, 32'(rd_req[k]), 0);
  endtask

  initial begin
    int t0;
    int c;
    int dn;
    rst_n = 1'b0; init_end = 1'b0; inject = 1'b0;
    start[0] = 1'b0; start[1] = 1'b0;
    exp_err_set = 0; exp_tmo_set = 1'b0;
    n_checks = 0; n_errors = 0;
    fork
      forever begin
        @(negedge clk_50m);
        monitor_step();
      end
    join_none

    repeat (3) @(posedge clk_50m);
    #1;
    check_all_zero("rst0", 0);
    check_all_zero("rst1", 1);
    rst_n = 1'b1;
    repeat (2) @(posedge clk_50m);

    // init_end never arrives: abort after TIMEOUT cycles with no FIFO traffic
    exp_tmo_set = 1'b1; exp_err_set = 0;
    pulse_start(0);
    t0 = cyc;
    wait_done(0, 400);
    check_eq("u0_tmo_latency_in_window", 32'((done_cyc[0] - t0) >= 98 && (done_cyc[0] - t0) <= 104), 1);

    init_end = 1'b1;
    exp_tmo_set = 1'b0;

    // Clean incrementing run
    exp_err_set = 0;
    pulse_start(0);
    wait_done(0, 3000);

    // Bit 3 forced on read word 5
    inject = 1'b1; exp_err_set = 1;
    pulse_start(0);
    wait_done(0, 3000);
    inject = 1'b0; exp_err_set = 0;

    // LFSR, three passes, single word, no gap
    pulse_start(1);
    wait_done(1, 3000);

    // Second start during DRAIN must be ignored
    pulse_start(0);
    c = 0;
    while (!rd_req[0] && c < 3000) begin
      @(posedge clk_50m); #1;
      c++;
    end
    check_eq("u0_reached_drain", 32'(rd_req[0]), 1);
    pulse_start(0);
    check_eq("u0_busy_after_restart", 32'(busy[0]), 1);
    wait_done(0, 3000);
    dn = done_cnt[0];
    repeat (60) @(posedge clk_50m);
    #1;
    check_eq("u0_no_extra_done", 32'(done_cnt[0]), 32'(dn));
    check_eq("u0_idle_after_done", 32'(busy[0]), 0);

    // Async reset in the middle of WRITE
    pulse_start(0);
    c = 0;
    while (pushes_run[0] < 3 && c < 3000) begin
      @(posedge clk_50m); #1;
      c++;
    end
    check_eq("u0_reached_write", 32'(pushes_run[0] >= 3), 1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midrst", 0);
    @(posedge clk_50m); #1;
    rst_n = 1'b1;

    // Recovery run after reset
    pulse_start(0);
    wait_done(0, 3000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
